// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a K=3 rate-1/2 convolutional encoder: clear, info bits, tail flush, G0/G1 phasing.
// Optional rate-2/3 puncturing when CONV_PUNCT_EN is defined.
module conv_frame_ctrl #(
    parameter int LEN_W = 8,
    parameter int TAIL  = 2,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             enc_clr,
    output logic             enc_shift,
    output logic             enc_bit,
    output logic             enc_phase,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             done
);

    localparam int TW = $clog2(TAIL + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_EMIT0, S_EMIT1, S_GAP
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] info_left, info_nxt;
    logic [TW-1:0]    tail_left, tail_nxt;
    logic [GW-1:0]    gap_cnt, gap_nxt;
    // odd_bit: index of the bit currently in the encoder is odd
    logic             odd_bit, odd_nxt;
    logic             first, first_nxt;
    logic             last_bit;

    assign last_bit = (info_left == '0) && (tail_left == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            info_left <= '0;
            tail_left <= '0;
            gap_cnt   <= '0;
            odd_bit   <= 1'b0;
            first     <= 1'b0;
        end else begin
            state     <= state_nxt;
            info_left <= info_nxt;
            tail_left <= tail_nxt;
            gap_cnt   <= gap_nxt;
            odd_bit   <= odd_nxt;
            first     <= first_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        info_nxt  = info_left;
        tail_nxt  = tail_left;
        gap_nxt   = gap_cnt;
        odd_nxt   = odd_bit;
        first_nxt = first;
        busy      = (state != S_IDLE);
        in_ready  = 1'b0;
        enc_clr   = 1'b0;
        enc_shift = 1'b0;
        enc_bit   = 1'b0;
        enc_phase = 1'b0;
        out_valid = 1'b0;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    busy      = 1'b1;
                    info_nxt  = frame_len;
                    tail_nxt  = TW'(TAIL);
                    odd_nxt   = 1'b1;  // first shift toggles to index 0
                    first_nxt = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                enc_clr = 1'b1;
                if (info_left == '0) begin
                    // empty frame: first tail zero goes in alongside the clear
                    enc_shift = 1'b1;
                    tail_nxt  = tail_left - 1'b1;
                    odd_nxt   = ~odd_bit;
                    state_nxt = S_EMIT0;
                end else begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    enc_shift = 1'b1;
                    enc_bit   = in_bit;
                    info_nxt  = info_left - 1'b1;
                    odd_nxt   = ~odd_bit;
                    state_nxt = S_EMIT0;
                end
            end
            S_EMIT0: begin
                out_valid = 1'b1;
                out_sof   = first;
                first_nxt = 1'b0;
`ifdef CONV_PUNCT_EN
                out_eof   = last_bit & odd_bit;
`endif
                state_nxt = S_EMIT1;
            end
            S_EMIT1: begin
                enc_phase = 1'b1;
`ifdef CONV_PUNCT_EN
                out_valid = ~odd_bit;
                out_eof   = last_bit & ~odd_bit;
`else
                out_valid = 1'b1;
                out_eof   = last_bit;
`endif
                // next bit is shifted in the same cycle; output still uses old register
                if (info_left != '0) begin
                    if (in_valid) begin
                        in_ready  = 1'b1;
                        enc_shift = 1'b1;
                        enc_bit   = in_bit;
                        info_nxt  = info_left - 1'b1;
                        odd_nxt   = ~odd_bit;
                        state_nxt = S_EMIT0;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end else if (tail_left != '0) begin
                    enc_shift = 1'b1;
                    tail_nxt  = tail_left - 1'b1;
                    odd_nxt   = ~odd_bit;
                    state_nxt = S_EMIT0;
                end else begin
                    gap_nxt   = '0;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                done = (gap_cnt == '0);
                if (gap_cnt == GW'(GAP - 1)) begin
                    gap_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
